// File: rtl/fpu_sched.sv
// Round-robin front end sharing one pipelined single-precision FPU among N_REQ requesters.
// Results return in accept order through a credit-protected first-word fall-through FIFO.
module fpu_sched #(
    parameter int N_REQ     = 4,
    parameter int FPU_LAT   = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [3*N_REQ-1:0]         req_op,
    input  logic [2*N_REQ-1:0]         req_rmode,
    input  logic [32*N_REQ-1:0]        req_opa,
    input  logic [32*N_REQ-1:0]        req_opb,
    output logic [2:0]                 fpu_op,
    output logic [1:0]                 fpu_rmode,
    output logic [31:0]                fpu_opa,
    output logic [31:0]                fpu_opb,
    input  logic [31:0]                fpu_out,
    input  logic [7:0]                 fpu_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [31:0]                rsp_out,
    output logic [7:0]                 rsp_flags,
    output logic                       rsp_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int TAGS  = FPU_LAT + 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(2 * (RSP_DEPTH + TAGS));
    localparam int ENT_W = ID_W + 1 + 8 + 32;

    function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] i);
        return (i == ID_W'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      cand;
    logic [ID_W-1:0]      gnt_id;
    logic                 found;
    logic                 acc_p0;
    logic                 credit_ok;
    logic [2:0]           acc_op;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     fifo_count;

    logic [TAGS-1:0]      tag_vld_p;
    logic [TAGS-1:0]      tag_err_p;
    logic [TAGS*ID_W-1:0] tag_id_p;

    logic                 cap_vld;
    logic                 cap_err;
    logic [ENT_W-1:0]     cap_entry;
    logic                 pop;
    logic [ENT_W-1:0]     fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < TAGS; k++)
            inflight = inflight + CNT_W'(tag_vld_p[k]);
    end

    // A pop only frees credit once fifo_count has actually dropped.
    assign credit_ok = (inflight + fifo_count) < CNT_W'(RSP_DEPTH);

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
            cand = id_inc(cand);
        end
        acc_p0    = found & credit_ok & ~rst;
        req_ready = '0;
        if (acc_p0)
            req_ready[gnt_id] = 1'b1;
    end

    assign acc_op = req_op[3*gnt_id +: 3];

    // Stage p0: issue to FPU; illegal ops leave the FPU inputs untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            fpu_op    <= '0;
            fpu_rmode <= '0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
        end else if (acc_p0) begin
            rr_ptr <= id_inc(gnt_id);
            if (!acc_op[2]) begin
                fpu_op    <= acc_op;
                fpu_rmode <= req_rmode[2*gnt_id +: 2];
                fpu_opa   <= req_opa[32*gnt_id +: 32];
                fpu_opb   <= req_opb[32*gnt_id +: 32];
            end
        end
    end

    // Tag pipeline: the extra stage lines the last tag up with the FPU output window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_p <= '0;
            tag_err_p <= '0;
            tag_id_p  <= '0;
        end else begin
            tag_vld_p <= {tag_vld_p[TAGS-2:0], acc_p0};
            tag_err_p <= {tag_err_p[TAGS-2:0], acc_p0 & acc_op[2]};
            tag_id_p  <= {tag_id_p[(TAGS-1)*ID_W-1:0], gnt_id};
        end
    end

    // Capture boundary: FPU result plus tag into the response FIFO.
    assign cap_vld   = tag_vld_p[TAGS-1];
    assign cap_err   = tag_err_p[TAGS-1];
    assign cap_entry = {tag_id_p[TAGS*ID_W-1 -: ID_W], cap_err,
                        cap_err ? 8'h00 : fpu_flags,
                        cap_err ? 32'h0 : fpu_out};

    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (cap_vld)
            fifo_mem[wr_ptr] <= cap_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (cap_vld)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(cap_vld) - CNT_W'(pop);
        end
    end

    assign {rsp_id, rsp_err, rsp_flags, rsp_out} = rsp_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fpu_sched.sv
// Directed bench for fpu_sched: stub FPU with fixed latency, accept/response monitor,
// hand-computed expectations for add, divide-by-zero, contention, backpressure, illegal op and reset.
module tb_fpu_sched;

    localparam int N_REQ     = 4;
    localparam int FPU_LAT   = 4;
    localparam int RSP_DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_op;
    logic [2*N_REQ-1:0]     req_rmode;
    logic [32*N_REQ-1:0]    req_opa;
    logic [32*N_REQ-1:0]    req_opb;
    logic [2:0]             fpu_op;
    logic [1:0]             fpu_rmode;
    logic [31:0]            fpu_opa;
    logic [31:0]            fpu_opb;
    logic [31:0]            fpu_out;
    logic [7:0]             fpu_flags;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [31:0]            rsp_out;
    logic [7:0]             rsp_flags;
    logic                   rsp_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int          acc_id_q[$];
    int          acc_edge_q[$];
    int          rsp_id_q[$];
    int          rsp_err_q[$];
    int          rsp_cyc_q[$];
    logic [31:0] rsp_out_q[$];
    logic [7:0]  rsp_flags_q[$];

    fpu_sched #(.N_REQ(N_REQ), .FPU_LAT(FPU_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rmode(req_rmode), .req_opa(req_opa), .req_opb(req_opb),
        .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
        .fpu_out(fpu_out), .fpu_flags(fpu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub FPU: inputs sampled each edge, result appears FPU_LAT cycles after presentation.
    logic [2:0]  st_op [FPU_LAT];
    logic [31:0] st_a  [FPU_LAT];
    logic [31:0] st_b  [FPU_LAT];

    always @(posedge clk) begin
        st_op[0] <= fpu_op;
        st_a[0]  <= fpu_opa;
        st_b[0]  <= fpu_opb;
        for (int k = 1; k < FPU_LAT; k++) begin
            st_op[k] <= st_op[k-1];
            st_a[k]  <= st_a[k-1];
            st_b[k]  <= st_b[k-1];
        end
    end

    function automatic logic [39:0] fpu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (op == 3'b000 && a == 32'h3F800000 && b == 32'h3F800000)
            return {8'h00, 32'h40000000};
        else if (op == 3'b011 && b == 32'h0)
            return {8'h81, 32'h7F800000};
        else
            return {8'h10, a ^ b};
    endfunction

    assign {fpu_flags, fpu_out} = fpu_model(st_op[FPU_LAT-1], st_a[FPU_LAT-1], st_b[FPU_LAT-1]);

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_id_q.push_back(i);
                    acc_edge_q.push_back(cyc + 1);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_id_q.push_back(int'(rsp_id));
                rsp_err_q.push_back(int'(rsp_err));
                rsp_out_q.push_back(rsp_out);
                rsp_flags_q.push_back(rsp_flags);
                rsp_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        acc_id_q.delete();
        acc_edge_q.delete();
        rsp_id_q.delete();
        rsp_err_q.delete();
        rsp_out_q.delete();
        rsp_flags_q.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [1:0] rm,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[3*id +: 3]     = op;
        req_rmode[2*id +: 2]  = rm;
        req_opa[32*id +: 32]  = a;
        req_opb[32*id +: 32]  = b;
    endtask

    task automatic issue(input int id, input logic [2:0] op, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        set_req(id, op, rm, a, b);
        req_valid[id] = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (!ok)
            chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input string tag, input int n, input int budget);
        for (int t = 0; t < budget && rsp_out_q.size() < n; t++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_count"}, rsp_out_q.size(), n);
    endtask

    task automatic chk_rsp(input string tag, input int k, input int id, input logic [31:0] out,
                           input logic [7:0] fl, input logic err);
        if (k < rsp_out_q.size()) begin
            chk({tag, "_id"},    rsp_id_q[k],    id);
            chk({tag, "_out"},   rsp_out_q[k],   out);
            chk({tag, "_flags"}, rsp_flags_q[k], fl);
            chk({tag, "_err"},   rsp_err_q[k],   err);
        end else begin
            chk({tag, "_missing"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_rmode = '0;
        req_opa   = '1;
        req_opb   = '1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fpu_op",    fpu_op,    0);
        chk("rst_fpu_rmode", fpu_rmode, 0);
        chk("rst_fpu_opa",   fpu_opa,   0);
        chk("rst_fpu_opb",   fpu_opb,   0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id",    rsp_id,    0);
        chk("rst_rsp_out",   rsp_out,   0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_err",   rsp_err,   0);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
        clear_q();
        repeat (6) @(posedge clk);
        #1;

        // single add, 1.0 + 1.0 from requester 2
        issue(2, 3'b000, 2'b00, 32'h3F800000, 32'h3F800000);
        chk("add_fpu_opa", fpu_opa, 32'h3F800000);
        chk("add_fpu_op",  fpu_op,  3'b000);
        wait_rsp("add", 1, 20);
        if (rsp_cyc_q.size() > 0 && acc_edge_q.size() > 0)
            chk("add_latency", rsp_cyc_q[0] - acc_edge_q[0], FPU_LAT + 1);
        chk_rsp("add", 0, 2, 32'h40000000, 8'h00, 1'b0);
        clear_q();

        // divide by zero from requester 1
        issue(1, 3'b011, 2'b00, 32'h3F800000, 32'h00000000);
        wait_rsp("div", 1, 20);
        chk_rsp("div", 0, 1, 32'h7F800000, 8'h81, 1'b0);

        // all four requesters valid from reset: grants 0,1,2,3,... one per cycle
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            set_req(i, 3'b000, 2'b00, 32'h100 + i, 32'h0);
        req_valid = '1;
        repeat (12) @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp("cont", 12, 40);
        chk("cont_acc_count", acc_id_q.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < acc_id_q.size()) begin
                chk("cont_gnt_id",   acc_id_q[k], k % 4);
                chk("cont_gnt_edge", acc_edge_q[k] - acc_edge_q[0], k);
            end
            chk_rsp("cont", k, k % 4, 32'h100 + (k % 4), 8'h10, 1'b0);
        end

        // backpressure: exactly RSP_DEPTH accepts, then stall until a pop
        clear_q();
        rsp_ready = 1'b0;
        for (int k = 0; k < RSP_DEPTH; k++)
            issue(0, 3'b000, 2'b00, 32'h200 + k, 32'h0);
        set_req(0, 3'b000, 2'b00, 32'h200 + RSP_DEPTH, 32'h0);
        req_valid[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_acc_count", acc_id_q.size(), RSP_DEPTH);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_no_pop",    rsp_out_q.size(), 0);
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && acc_id_q.size() < RSP_DEPTH + 1; t++) begin
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        chk("bp_resume", acc_id_q.size(), RSP_DEPTH + 1);
        wait_rsp("bp", RSP_DEPTH + 1, 40);
        for (int k = 0; k <= RSP_DEPTH; k++)
            chk_rsp("bp", k, 0, 32'h200 + k, 8'h10, 1'b0);

        // illegal opcode between two adds
        clear_q();
        issue(3, 3'b000, 2'b01, 32'h11, 32'h22);
        issue(1, 3'b100, 2'b10, 32'h55, 32'h66);
        chk("ill_fpu_op",    fpu_op,    3'b000);
        chk("ill_fpu_rmode", fpu_rmode, 2'b01);
        chk("ill_fpu_opa",   fpu_opa,   32'h11);
        issue(3, 3'b000, 2'b00, 32'h44, 32'h0);
        wait_rsp("ill", 3, 30);
        chk_rsp("ill0", 0, 3, 32'h33, 8'h10, 1'b0);
        chk_rsp("ill1", 1, 1, 32'h0,  8'h00, 1'b1);
        chk_rsp("ill2", 2, 3, 32'h44, 8'h10, 1'b0);

        // reset two cycles after three accepts; pointer left at 2 beforehand
        clear_q();
        issue(3, 3'b000, 2'b00, 32'h301, 32'h0);
        issue(0, 3'b000, 2'b00, 32'h302, 32'h0);
        issue(1, 3'b000, 2'b00, 32'h303, 32'h0);
        @(posedge clk);
        do_reset();
        repeat (15) @(posedge clk);
        #1;
        chk("rst_no_rsp",      rsp_out_q.size(), 0);
        chk("rst_rsp_valid_2", rsp_valid, 0);
        set_req(0, 3'b000, 2'b00, 32'h401, 32'h0);
        set_req(2, 3'b000, 2'b00, 32'h402, 32'h0);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("rst_first_gnt", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_second_gnt", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_rsp("post_rst", 2, 30);
        chk_rsp("post_rst0", 0, 0, 32'h401, 8'h10, 1'b0);
        chk_rsp("post_rst1", 1, 2, 32'h402, 8'h10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
